tt_uio_arbiter: RTL and testbench
=================================

Name: tt_uio_arbiter

Overview:
- Shares the eight bidirectional uio pins (uio_in/uio_out/uio_oe) of the tt_um top level between NREQ internal requesters.
- Uses round-robin arbitration, with a bounded hold time per requester.
- Inserts idle turnaround cycles whenever the pin direction flips, so pins are never driven while the external side may still be driving them.
- Sits between the user logic and the uio pins inside tt_um_example.

Parameters:
- NREQ, 4: number of requesters (2..8).
- HOLD_MAX, 8: maximum OWN cycles per grant while another requester waits. 0 disables preemption.
- TURN_CYC, 2: idle cycles inserted on a direction change (1..15).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous and active-low.
- ena  input  1  design enable. Low forces idle.
- req  input  NREQ  per-requester request, level, held while ownership is wanted.
- dir  input  NREQ  per-requester direction, 1 = drive pins, 0 = sample pins. Must be stable while req is high.
- wdata  input  8*NREQ  per-requester output byte. Requester i uses bits [8i+7:8i].
- uio_in  input  8  pin input path.
- uio_out  output  8  pin output path.
- uio_oe  output  8  pin output enable.
- gnt  output  NREQ  one-hot grant. All zero when no requester owns the pins.
- rdata  output  8  registered sample of uio_in.
- rvalid  output  1  rdata was captured in OWN for an input-direction owner.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset values:
  - state = IDLE; gnt = 0; uio_oe = 0; uio_out = 0; rdata = 0; rvalid = 0; busy = 0.
  - last_dir = 0 (input); rr pointer last = NREQ-1, so req[0] has first priority.
  - hold counter = 0; turn counter = 0.
- Outputs: all outputs are registered except busy, which is decoded from state.
- States:
  - IDLE: no owner, uio_oe = 0.
    - On an edge with ena = 1 and any req bit high, select the winner w: the first set bit scanning from last+1 upward, modulo NREQ.
    - Latch owner = w and last = w.
    - If dir[w] != last_dir, go to TURN with turn counter = TURN_CYC-1.
    - Otherwise go to OWN.
  - TURN: gnt = 0, uio_oe = 0, uio_out = 0.
    - Decrement the turn counter each cycle. At 0, go to OWN and set last_dir = dir[owner].
    - If req[owner] drops during TURN, return to IDLE. last_dir is unchanged.
  - OWN: gnt[owner] = 1; uio_oe = 8'hFF if dir[owner] = 1, else 8'h00.
    - uio_out = the owner's wdata slice when driving, else 0. It is registered, so it follows wdata with 1-cycle lag.
    - When the owner direction is input, rdata <= uio_in every cycle and rvalid = 1.
    - The hold counter increments each OWN cycle.
    - Leave to IDLE (gnt, uio_oe and rvalid cleared at that edge) when either:
      - req[owner] = 0; or
      - HOLD_MAX != 0, hold counter = HOLD_MAX-1, and any other req bit is high (preemption).
    - If no other request is pending, the hold counter saturates and ownership continues.
- Grant latency, from the first edge sampling req high in IDLE:
  - 1 cycle to gnt with no direction change.
  - 1+TURN_CYC cycles with a direction change.
- After release, IDLE always lasts at least 1 cycle before the next grant. This makes the bus gap at least 1 cycle.
- Simultaneous requests are resolved by round-robin only, so the last owner has lowest priority next time.
- A requester that drops and re-raises req in the same IDLE cycle competes normally.
- ena = 0: next edge goes to IDLE from any state; gnt, uio_oe and rvalid are cleared. The rr pointer and last_dir are retained. No grant is issued while ena = 0.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous). uio_oe = 0 without waiting for a clock.
- Invariants:
  - At most one gnt bit is set.
  - uio_oe is only ever 8'h00 or 8'hFF.
  - uio_oe != 0 only in OWN with dir[owner] = 1.
  - uio_oe never transitions 0xFF->0x00->0xFF or back without at least TURN_CYC zero cycles between owners of opposite direction.

Test Plan:
- Reset, then req = 4'b0001 with dir[0] = 0 → gnt = 0001 one cycle later; uio_oe = 00, no TURN. Drive uio_in = 8'hA5 → rdata = A5 and rvalid = 1 next cycle.
- req[1] only, dir[1] = 1, wdata[15:8] = 8'h3C, TURN_CYC = 2 → gnt = 0 for 2 TURN cycles, then gnt = 0010, uio_oe = FF, uio_out = 3C.
- req = 4'b1111 held, all dir = 0, HOLD_MAX = 8 → grants rotate 0,1,2,3,0. Each OWN lasts exactly 8 cycles, with a 1-cycle IDLE gap between owners.
- Owner 2 (output) releases while req[3] (input) is pending → IDLE 1 cycle, TURN 2 cycles with uio_oe = 00, then gnt = 1000.
- ena dropped during OWN with uio_oe = FF → next edge gnt = 0, uio_oe = 00. With ena restored and the same req, a grant returns with no TURN, because last_dir was retained.
- rst_n pulsed low mid-OWN (output) → uio_oe = 00 and gnt = 0 asynchronously, before the next clock edge. The first subsequent grant goes to req[0] if it is set.

Source files
------------

// File: rtl/tt_uio_arbiter.sv
// Round-robin owner of the shared uio pins, with bounded hold time and turnaround on direction flips.
// Latency: grant 1 cycle after req is sampled in IDLE, or 1+TURN_CYC cycles when the pin direction changes.
// Backpressure: requesters hold req until gnt; the owner is preempted after HOLD_MAX cycles if another requester waits.
module tt_uio_arbiter #(
  parameter int NREQ     = 4,
  parameter int HOLD_MAX = 8,
  parameter int TURN_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   dir,
  input  logic [8*NREQ-1:0] wdata,
  input  logic [7:0]        uio_in,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe,
  output logic [NREQ-1:0]   gnt,
  output logic [7:0]        rdata,
  output logic              rvalid,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
  localparam logic [3:0]    TURN_INIT = 4'(TURN_CYC - 1);
  localparam logic [IW-1:0] LAST_INIT = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    OWN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   last_q, last_d;
  logic            last_dir_q, last_dir_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [3:0]      turn_q, turn_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [7:0]      oe_q, oe_d;
  logic [7:0]      out_q, out_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;

  logic [IW-1:0]   win;
  logic            win_found;
  logic [IW-1:0]   scan_idx;
  logic [NREQ-1:0] owner_oh;
  logic            others_pending;
  logic            go_own;

  // Round-robin pick: first requester after the last owner, wrapping modulo NREQ.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    scan_idx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = IW'((int'(last_q) + k) % NREQ);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win       = scan_idx;
      end
    end
  end

  assign owner_oh       = NREQ'(1) << owner_q;
  assign others_pending = |(req & ~owner_oh);

  // Next-state and registered-output decode; pin outputs only become active in OWN.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    last_dir_d = last_dir_q;
    hold_d     = hold_q;
    turn_d     = turn_q;
    gnt_d      = '0;
    oe_d       = 8'h00;
    out_d      = 8'h00;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    go_own     = 1'b0;

    if (!ena) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            owner_d = win;
            last_d  = win;
            if (dir[win] != last_dir_q) begin
              state_d = TURN;
              turn_d  = TURN_INIT;
            end else begin
              go_own = 1'b1;
            end
          end
        end
        TURN: begin
          if (!req[owner_q]) begin
            state_d = IDLE;
          end else if (turn_q == 4'd0) begin
            go_own     = 1'b1;
            last_dir_d = dir[owner_q];
          end else begin
            turn_d = turn_q - 4'd1;
          end
        end
        OWN: begin
          if (!req[owner_q] ||
              ((HOLD_MAX != 0) && (hold_q == HOLD_LAST) && others_pending)) begin
            state_d = IDLE;
          end else begin
            // Saturate so a lone owner keeps the pins indefinitely.
            if ((HOLD_MAX != 0) && (hold_q != HOLD_LAST)) begin
              hold_d = hold_q + HW'(1);
            end
            if (!dir[owner_q]) begin
              rdata_d  = uio_in;
              rvalid_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (go_own) begin
      state_d = OWN;
      hold_d  = '0;
    end

    if (state_d == OWN) begin
      gnt_d = NREQ'(1) << owner_d;
      if (dir[owner_d]) begin
        oe_d  = 8'hFF;
        out_d = wdata[{owner_d, 3'b000} +: 8];
      end
    end
  end

  // State and output registers; reset drops the pin enables immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      last_q     <= LAST_INIT;
      last_dir_q <= 1'b0;
      hold_q     <= '0;
      turn_q     <= '0;
      gnt_q      <= '0;
      oe_q       <= 8'h00;
      out_q      <= 8'h00;
      rdata_q    <= 8'h00;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      last_dir_q <= last_dir_d;
      hold_q     <= hold_d;
      turn_q     <= turn_d;
      gnt_q      <= gnt_d;
      oe_q       <= oe_d;
      out_q      <= out_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign gnt     = gnt_q;
  assign uio_oe  = oe_q;
  assign uio_out = out_q;
  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_tt_uio_arbiter.sv
module tb_tt_uio_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [3:0]  req;
  logic [3:0]  dir;
  logic [31:0] wdata;
  logic [7:0]  uio_in;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;
  logic [3:0]  gnt;
  logic [7:0]  rdata;
  logic        rvalid;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  tt_uio_arbiter #(.NREQ(4), .HOLD_MAX(8), .TURN_CYC(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .req     (req),
    .dir     (dir),
    .wdata   (wdata),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .gnt     (gnt),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ena;
    logic [3:0]  req;
    logic [3:0]  dir;
    logic [31:0] wdata;
    logic [7:0]  uin;
    logic [3:0]  gnt;
    logic [7:0]  oe;
    logic [7:0]  out;
    logic [7:0]  rdata;
    logic        rvalid;
    logic        busy;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic [3:0] r, input logic [3:0] d,
                     input logic [31:0] w, input logic [7:0] ui,
                     input logic [3:0] g, input logic [7:0] oe, input logic [7:0] o,
                     input logic [7:0] rd, input logic rv, input logic b);
    vec_t v;
    v.ena = e; v.req = r; v.dir = d; v.wdata = w; v.uin = ui;
    v.gnt = g; v.oe = oe; v.out = o; v.rdata = rd; v.rvalid = rv; v.busy = b;
    tbl.push_back(v);
  endtask

  // One clock: outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Structural invariants checked on every falling edge outside reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_vec++;
      if ($countones(gnt) > 1 || !(uio_oe == 8'h00 || uio_oe == 8'hFF) ||
          (uio_oe != 8'h00 && gnt == 4'b0000)) begin
        n_err++;
        $display("FAIL invariant: gnt=%b uio_oe=%h", gnt, uio_oe);
      end
    end
  end

  localparam logic [31:0] W0 = 32'h009E_3C00;
  localparam logic [31:0] W1 = 32'h009E_C300;

  initial begin
    rst_n = 1'b0; ena = 1'b1; req = '0; dir = '0; wdata = W0; uio_in = 8'h00;

    //   ena req      dir      wdata uin     gnt      oe     out    rdata  rv  busy
    add(1, 4'b0001, 4'b0000, W0, 8'h00, 4'b0001, 8'h00, 8'h00, 8'h00, 0, 1); // 0 input owner, no turn
    add(1, 4'b0001, 4'b0000, W0, 8'hA5, 4'b0001, 8'h00, 8'h00, 8'hA5, 1, 1); // 1 capture
    add(1, 4'b0000, 4'b0000, W0, 8'hA5, 4'b0000, 8'h00, 8'h00, 8'hA5, 0, 0); // 2 release
    add(1, 4'b0010, 4'b0010, W0, 8'hA5, 4'b0000, 8'h00, 8'h00, 8'hA5, 0, 1); // 3 TURN
    add(1, 4'b0010, 4'b0010, W0, 8'hA5, 4'b0000, 8'h00, 8'h00, 8'hA5, 0, 1); // 4 TURN
    add(1, 4'b0010, 4'b0010, W0, 8'hA5, 4'b0010, 8'hFF, 8'h3C, 8'hA5, 0, 1); // 5 drive 3C
    add(1, 4'b0010, 4'b0010, W1, 8'hA5, 4'b0010, 8'hFF, 8'hC3, 8'hA5, 0, 1); // 6 wdata follows
    add(1, 4'b1000, 4'b0010, W1, 8'hA5, 4'b0000, 8'h00, 8'h00, 8'hA5, 0, 0); // 7 release, IDLE
    add(1, 4'b1000, 4'b0010, W1, 8'hA5, 4'b0000, 8'h00, 8'h00, 8'hA5, 0, 1); // 8 TURN to input
    add(1, 4'b1000, 4'b0010, W1, 8'hA5, 4'b0000, 8'h00, 8'h00, 8'hA5, 0, 1); // 9 TURN
    add(1, 4'b1000, 4'b0010, W1, 8'hA5, 4'b1000, 8'h00, 8'h00, 8'hA5, 0, 1); // 10 owner 3
    add(1, 4'b1000, 4'b0010, W1, 8'h77, 4'b1000, 8'h00, 8'h00, 8'h77, 1, 1); // 11 capture
    add(1, 4'b0000, 4'b0010, W1, 8'h77, 4'b0000, 8'h00, 8'h00, 8'h77, 0, 0); // 12 release
    add(1, 4'b0100, 4'b0100, W1, 8'h77, 4'b0000, 8'h00, 8'h00, 8'h77, 0, 1); // 13 TURN owner 2
    add(1, 4'b0000, 4'b0100, W1, 8'h77, 4'b0000, 8'h00, 8'h00, 8'h77, 0, 0); // 14 drop in TURN
    add(1, 4'b0001, 4'b0000, W1, 8'h77, 4'b0001, 8'h00, 8'h00, 8'h77, 0, 1); // 15 last_dir kept
    add(1, 4'b0000, 4'b0000, W1, 8'h77, 4'b0000, 8'h00, 8'h00, 8'h77, 0, 0); // 16
    add(1, 4'b0011, 4'b0000, W1, 8'h77, 4'b0010, 8'h00, 8'h00, 8'h77, 0, 1); // 17 rr -> 1
    add(1, 4'b0000, 4'b0000, W1, 8'h77, 4'b0000, 8'h00, 8'h00, 8'h77, 0, 0); // 18
    add(1, 4'b0011, 4'b0000, W1, 8'h77, 4'b0001, 8'h00, 8'h00, 8'h77, 0, 1); // 19 rr -> 0
    add(1, 4'b0000, 4'b0000, W1, 8'h77, 4'b0000, 8'h00, 8'h00, 8'h77, 0, 0); // 20
    add(1, 4'b0100, 4'b0100, W1, 8'h77, 4'b0000, 8'h00, 8'h00, 8'h77, 0, 1); // 21 TURN owner 2
    add(1, 4'b0100, 4'b0100, W1, 8'h77, 4'b0000, 8'h00, 8'h00, 8'h77, 0, 1); // 22
    add(1, 4'b0100, 4'b0100, W1, 8'h77, 4'b0100, 8'hFF, 8'h9E, 8'h77, 0, 1); // 23 drive 9E
    add(0, 4'b0100, 4'b0100, W1, 8'h77, 4'b0000, 8'h00, 8'h00, 8'h77, 0, 0); // 24 ena low
    add(0, 4'b0100, 4'b0100, W1, 8'h77, 4'b0000, 8'h00, 8'h00, 8'h77, 0, 0); // 25 no grant
    add(1, 4'b0100, 4'b0100, W1, 8'h77, 4'b0100, 8'hFF, 8'h9E, 8'h77, 0, 1); // 26 no TURN

    // Reset values while held in reset.
    step();
    step();
    chk("reset gnt", 32'(gnt), 32'h0);
    chk("reset uio_oe", 32'(uio_oe), 32'h0);
    chk("reset uio_out", 32'(uio_out), 32'h0);
    chk("reset rdata", 32'(rdata), 32'h0);
    chk("reset rvalid", 32'(rvalid), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      ena = tbl[i].ena; req = tbl[i].req; dir = tbl[i].dir;
      wdata = tbl[i].wdata; uio_in = tbl[i].uin;
      step();
      chk($sformatf("row%0d gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("row%0d uio_oe", i), 32'(uio_oe), 32'(tbl[i].oe));
      chk($sformatf("row%0d uio_out", i), 32'(uio_out), 32'(tbl[i].out));
      chk($sformatf("row%0d rdata", i), 32'(rdata), 32'(tbl[i].rdata));
      chk($sformatf("row%0d rvalid", i), 32'(rvalid), 32'(tbl[i].rvalid));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].busy));
    end

    // Asynchronous reset while owner 2 is driving: pins released before any edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst gnt", 32'(gnt), 32'h0);
    chk("async rst uio_oe", 32'(uio_oe), 32'h0);
    chk("async rst uio_out", 32'(uio_out), 32'h0);
    chk("async rst busy", 32'(busy), 32'h0);
    step();
    rst_n = 1'b1;
    req = 4'b0101; dir = 4'b0000;
    step();
    chk("post-reset first gnt", 32'(gnt), 32'h1);
    chk("post-reset uio_oe", 32'(uio_oe), 32'h0);
    req = 4'b0000;
    step();
    chk("post-reset release", 32'(gnt), 32'h0);

    // All requesting, all input: 8-cycle slots, 1-cycle gap, rotating from 1.
    req = 4'b1111; dir = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 8; c++) begin
        step();
        chk($sformatf("rot%0d cyc%0d gnt", k, c), 32'(gnt), 32'(4'b0001 << ((k + 1) % 4)));
      end
      if (k < 4) begin
        step();
        chk($sformatf("rot%0d gap gnt", k), 32'(gnt), 32'h0);
      end
    end

    // Lone owner past the hold limit keeps the pins.
    req = 4'b0010;
    for (int c = 0; c < 12; c++) begin
      step();
      chk($sformatf("saturate cyc%0d gnt", c), 32'(gnt), 32'h2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
